// File: rtl/imagem_pixel_streamer_pkg.sv
// Shared types and constants for the image pixel streamer.
package imagem_pixel_streamer_pkg;

  // Frame sequencer states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int PIXELS_PER_WORD = 4;
  localparam int PIXEL_W         = 8;
  localparam int WORD_W          = PIXELS_PER_WORD * PIXEL_W;
  localparam int BYTE_IDX_W      = $clog2(PIXELS_PER_WORD);

  // Image RAM returns data a fixed number of cycles after the address.
  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/imagem_word_fifo.sv
// Small synchronous word FIFO with first-word-fall-through read data.
module imagem_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage write.
  // NOTE: the storage array is deliberately not reset; the reset count and
  // pointers already mark every entry invalid, and a resettable array costs flops.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/imagem_pixel_streamer.sv
// Reads a frame of 32-bit words from the image RAM and streams it out as
// 8-bit pixels, least significant byte first, with sop/eop framing.
module imagem_pixel_streamer
  import imagem_pixel_streamer_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int LEN_W      = 19,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   num_words,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               mem_chipselect,
  output logic               mem_write,
  output logic [3:0]         mem_byteenable,
  output logic               mem_clken,
  input  logic [31:0]        mem_readdata,
  output logic [7:0]         st_data,
  output logic               st_valid,
  input  logic               st_ready,
  output logic               st_sop,
  output logic               st_eop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  state_e                r_state;
  state_e                w_next_state;
  logic [ADDR_W-1:0]     r_base;
  logic [LEN_W-1:0]      r_num;
  logic [LEN_W-1:0]      r_issued;
  logic [LEN_W-1:0]      r_word_cnt;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  logic [RD_LATENCY-1:0] r_rd_pipe;
  logic                  r_done;

  logic                  w_start_ok;
  logic                  w_issue;
  logic                  w_hs;
  logic                  w_last_byte;
  logic                  w_pop;
  logic                  w_last_hs;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [OCC_W-1:0]      w_occupancy;
  logic [WORD_W-1:0]     w_head;

  assign w_start_ok  = (r_state == ST_IDLE) && start;
  assign w_occupancy = {1'b0, w_fifo_count} + OCC_W'($countones(r_rd_pipe));
  // Only reserve a read if there will be room for its data when it returns.
  assign w_issue     = (r_state == ST_RUN) && (r_issued < r_num) &&
                       !w_fifo_full && (w_occupancy < DEPTH_OCC);
  assign w_hs        = st_valid && st_ready;
  assign w_last_byte = (r_byte_idx == BYTE_IDX_W'(PIXELS_PER_WORD - 1));
  assign w_pop       = w_hs && w_last_byte;
  assign w_last_hs   = w_hs && st_eop;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: a zero-length start completes without leaving IDLE.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start && (num_words != '0)) w_next_state = ST_RUN;
      ST_RUN:  if (w_last_hs)                  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Frame parameters and read issue tracking; starts while busy are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base    <= '0;
      r_num     <= '0;
      r_issued  <= '0;
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe <= (r_rd_pipe << 1) | RD_LATENCY'(w_issue);
      if (w_start_ok) begin
        r_base   <= base_addr;
        r_num    <= num_words;
        r_issued <= '0;
      end else if (w_issue) begin
        r_issued <= r_issued + LEN_W'(1);
      end
    end
  end

  // Unpacker position: byte within the head word and words fully consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_idx <= '0;
      r_word_cnt <= '0;
    end else if (w_start_ok) begin
      r_byte_idx <= '0;
      r_word_cnt <= '0;
    end else if (w_hs) begin
      r_byte_idx <= r_byte_idx + BYTE_IDX_W'(1);
      if (w_last_byte) r_word_cnt <= r_word_cnt + LEN_W'(1);
    end
  end

  // End-of-frame pulse, for both normal completion and zero-length frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= (w_start_ok && (num_words == '0)) || w_last_hs;
  end

  imagem_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_rd_pipe[RD_LATENCY-1]),
    .i_wdata (mem_readdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // RAM side: read-only master; the address wraps naturally at ADDR_W bits.
  assign mem_address    = r_base + r_issued[ADDR_W-1:0];
  assign mem_chipselect = w_issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  // Stream side.
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign st_valid = !w_fifo_empty;
  assign st_data  = st_valid ? w_head[r_byte_idx*PIXEL_W +: PIXEL_W] : '0;
  assign st_sop   = st_valid && (r_word_cnt == '0) && (r_byte_idx == '0);
  assign st_eop   = st_valid && w_last_byte && (r_word_cnt == r_num - LEN_W'(1));

endmodule

// File: tb/tb_imagem_pixel_streamer.sv
// Self-checking bench for imagem_pixel_streamer: behavioural RAM with one
// cycle read latency, scoreboard of expected pixels, and per-scenario tasks.
module tb_imagem_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [17:0] base_addr = '0;
  logic [18:0] num_words = '0;
  logic        busy, done;
  logic [17:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = '0;
  logic [7:0]  st_data;
  logic        st_valid, st_sop, st_eop;
  logic        st_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  exp_q[$];   // {sop, eop, data}
  logic [17:0] addr_q[$];
  logic [31:0] ram_over [int];

  int   cyc = 0;
  int   hs_cnt, cs_cnt, valid_cnt, done_cnt, eop_cnt, hs_first, hs_last;
  logic stall_prev = 1'b0;
  logic [7:0] prev_data = '0;

  imagem_pixel_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [17:0] a);
    if (ram_over.exists(int'(a))) return ram_over[int'(a)];
    return {a[7:0] ^ 8'h5A, a[15:8], {6'b0, a[17:16]}, a[7:0]};
  endfunction

  // Image RAM model, read latency 1.
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram_word(mem_address);
  end

  // Stream monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (busy) begin
        n_checks++;
        if ((cs_cnt + int'(mem_chipselect)) - hs_cnt / 4 > 2) begin
          n_errors++;
          $display("FAIL occupancy: words buffered+inflight %0d, limit 2",
                   (cs_cnt + int'(mem_chipselect)) - hs_cnt / 4);
        end
      end
      if (stall_prev) begin
        n_checks++;
        if (st_valid !== 1'b1 || st_data !== prev_data) begin
          n_errors++;
          $display("FAIL stall_hold: valid %b data %h, required valid 1 data %h",
                   st_valid, st_data, prev_data);
        end
      end
      if (st_valid && st_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL pixel: got unexpected pixel %h, required none", st_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({st_sop, st_eop, st_data} !== e) begin
            n_errors++;
            $display("FAIL pixel: got sop %b eop %b data %h, required sop %b eop %b data %h",
                     st_sop, st_eop, st_data, e[9], e[8], e[7:0]);
          end
        end
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL busy_in_frame: got %b required 1", busy);
        end
        if (hs_cnt == 0) hs_first = cyc;
        hs_last = cyc;
        hs_cnt++;
        if (st_eop) eop_cnt++;
      end
      if (st_valid) valid_cnt++;
      if (mem_chipselect) begin
        cs_cnt++;
        addr_q.push_back(mem_address);
      end
      if (done) done_cnt++;
      stall_prev = st_valid && !st_ready;
      prev_data  = st_data;
    end
  end

  task automatic clear_counts();
    hs_cnt = 0; cs_cnt = 0; valid_cnt = 0; done_cnt = 0; eop_cnt = 0;
    hs_first = 0; hs_last = 0;
    addr_q.delete();
  endtask

  task automatic push_frame(input logic [17:0] b, input int n);
    for (int w = 0; w < n; w++) begin
      logic [31:0] word;
      word = ram_word(b + 18'(w));
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(w == 0 && k == 0), (w == n - 1 && k == 3), word[8*k +: 8]});
    end
  endtask

  task automatic pulse_start(input logic [17:0] b, input logic [18:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [17:0] b, input int n, input bit bp, input bit mid_start);
    bit finished = 0;
    clear_counts();
    push_frame(b, n);
    st_ready = 1'b1;
    pulse_start(b, 19'(n));
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    for (int i = 0; i < 400 && !finished; i++) begin
      st_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mid_start && i == 3) begin
        start = 1'b1; base_addr = 18'h20; num_words = 19'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done_cnt != 0) finished = 1;
    end
    start = 1'b0;
    st_ready = 1'b1;
    n_checks++;
    if (!finished) begin
      n_errors++;
      $display("FAIL frame_timeout: done count %0d, required 1 within 400 cycles", done_cnt);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++;
      $display("FAIL done_count: got %0d required 1", done_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0 || hs_cnt != 4 * n) begin
      n_errors++;
      $display("FAIL pixel_count: got %0d pixels, %0d still expected, required %0d",
               hs_cnt, exp_q.size(), 4 * n);
    end
    n_checks++;
    if (eop_cnt != 1) begin
      n_errors++;
      $display("FAIL eop_count: got %0d required 1", eop_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || st_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_frame: busy %b valid %b required 0 0", busy, st_valid);
    end
    if (!bp) begin
      n_checks++;
      if (hs_last - hs_first != 4 * n - 1) begin
        n_errors++;
        $display("FAIL throughput: pixels spanned %0d cycles, required %0d",
                 hs_last - hs_first + 1, 4 * n);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, mem_chipselect, st_valid, st_sop, st_eop} !== 6'b0 ||
        mem_address !== 18'h0 || st_data !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_state: busy %b done %b cs %b valid %b sop %b eop %b addr %h data %h, required all 0",
               busy, done, mem_chipselect, st_valid, st_sop, st_eop, mem_address, st_data);
    end
    n_checks++;
    if (mem_write !== 1'b0 || mem_byteenable !== 4'hF || mem_clken !== 1'b1) begin
      n_errors++;
      $display("FAIL tie_offs: write %b be %h clken %b, required 0 f 1",
               mem_write, mem_byteenable, mem_clken);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    run_frame(18'h10, 2, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_frame(18'h10, 2, 1'b1, 1'b0);
    run_frame(18'h100, 3, 1'b1, 1'b0);
  endtask

  task automatic test_zero_length();
    clear_counts();
    pulse_start(18'h10, 19'd0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_done: got %b required 1", done);
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != 1 || valid_cnt != 0 || cs_cnt != 0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_quiet: done %0d valid %0d cs %0d busy %b, required 1 0 0 0",
               done_cnt, valid_cnt, cs_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    run_frame(18'h3FFFF, 2, 1'b0, 1'b0);
    n_checks++;
    if (addr_q.size() != 2) begin
      n_errors++;
      $display("FAIL wrap_reads: got %0d reads required 2", addr_q.size());
    end else if (addr_q[0] !== 18'h3FFFF || addr_q[1] !== 18'h00000) begin
      n_errors++;
      $display("FAIL wrap_addr: got %h %h required 3ffff 00000", addr_q[0], addr_q[1]);
    end
  endtask

  task automatic test_start_while_busy();
    run_frame(18'h10, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    bit reached = 0;
    clear_counts();
    push_frame(18'h10, 2);
    st_ready = 1'b1;
    pulse_start(18'h10, 19'd2);
    for (int i = 0; i < 100 && !reached; i++) begin
      @(posedge clk); #1;
      if (hs_cnt >= 3) reached = 1;
    end
    n_checks++;
    if (!reached) begin
      n_errors++;
      $display("FAIL mid_reset_wait: got %0d pixels required 3", hs_cnt);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (st_valid !== 1'b0 || busy !== 1'b0 || mem_chipselect !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_abort: valid %b busy %b cs %b required 0 0 0",
               st_valid, busy, mem_chipselect);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != 0 || eop_cnt != 0 || st_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_reset_quiet: done %0d eop %0d valid %b required 0 0 0",
               done_cnt, eop_cnt, st_valid);
    end
    run_frame(18'h10, 2, 1'b0, 1'b0);
  endtask

  initial begin
    ram_over[32'h10] = 32'h44332211;
    ram_over[32'h11] = 32'h88776655;
    clear_counts();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_length();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
